// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared BTB constants, update record and queue FSM state type
package btb_pkg;

    localparam int BTB_DEPTH = 64;
    localparam int BTB_INDEX = 6;
    localparam int BTB_WIDTH = 32;

    // One pending BTB write: which entry, and the packed tag/target/type to store there
    typedef struct packed {
        logic [BTB_INDEX-1:0] index;
        logic [BTB_WIDTH-1:0] data;
    } btb_upd_t;

    typedef enum logic {
        BTBQ_INIT,
        BTBQ_RUN
    } btbq_state_t;

endpackage

// File: rtl/btb_update_queue_if.sv
// rtl/btb_update_queue_if.sv - BTB update request handshake (valid/ready with index and data)
interface btb_update_queue_if #(
    parameter int INDEX = 6,
    parameter int WIDTH = 32
);

    logic             upd_valid_i;
    logic [INDEX-1:0] upd_index_i;
    logic [WIDTH-1:0] upd_data_i;
    logic             upd_ready_o;

    // Producer side: branch resolution / commit
    modport master (
        output upd_valid_i,
        output upd_index_i,
        output upd_data_i,
        input  upd_ready_o
    );

    // Consumer side: the update queue
    modport slave (
        input  upd_valid_i,
        input  upd_index_i,
        input  upd_data_i,
        output upd_ready_o
    );

endinterface

// File: rtl/btb_updq_fifo.sv
// rtl/btb_updq_fifo.sv - QDEPTH-entry circular FIFO of BTB update records
module btb_updq_fifo
    import btb_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int QIDX   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  btb_upd_t      i_wdata,
    output btb_upd_t      o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [QIDX:0] o_count
);

    btb_upd_t        r_mem [QDEPTH];
    logic [QIDX-1:0] r_wr_ptr;
    logic [QIDX-1:0] r_rd_ptr;
    logic [QIDX:0]   r_count;

    logic w_push;
    logic w_pop;

    // Occupancy never exceeds QDEPTH (a power of two), so the MSB alone marks full
    assign o_full  = r_count[QIDX];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage is cleared on reset so the head seen on the RAM port is never X
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally modulo QDEPTH; count tracks push/pop balance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + QIDX'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + QIDX'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (QIDX+1)'(1);
                2'b01:   r_count <= r_count - (QIDX+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - BTB write-port owner: post-reset zero sweep, then FIFO drain of updates (optional BTB_UPDQ_BYPASS_EN)
module btb_update_queue
    import btb_pkg::*;
#(
    parameter int DEPTH  = BTB_DEPTH,
    parameter int INDEX  = BTB_INDEX,
    parameter int WIDTH  = BTB_WIDTH,
    parameter int QDEPTH = 4,
    parameter int QIDX   = 2
) (
    input  logic                clk,
    input  logic                reset,
    btb_update_queue_if.slave   upd,
    input  logic                drain_stall_i,
    output logic [INDEX-1:0]    addr0wr_o,
    output logic [WIDTH-1:0]    data0wr_o,
    output logic                we0_o,
    output logic                init_done_o,
    output logic [QIDX:0]       count_o
);

    localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

    btbq_state_t      r_state;
    btbq_state_t      w_state_nxt;
    logic [INDEX-1:0] r_ptr;
    logic             r_init_done;

    logic             w_push;
    logic             w_pop;
    logic             w_ready;
    logic             w_full;
    logic             w_empty;
    btb_upd_t         w_head;
    btb_upd_t         w_wdata;

    assign w_wdata         = {upd.upd_index_i, upd.upd_data_i};
    assign upd.upd_ready_o = w_ready;
    assign init_done_o     = r_init_done;

    btb_updq_fifo #(
        .QDEPTH (QDEPTH),
        .QIDX   (QIDX)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    // State, sweep pointer and the sticky init-done flag raised on the INIT->RUN edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BTBQ_INIT;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == BTBQ_INIT) begin
                r_ptr <= r_ptr + INDEX'(1);
                if (r_ptr == LAST_IDX) begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    // Next state and write-port mux: sweep zeros in INIT, drain the queue head in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        we0_o       = 1'b0;
        addr0wr_o   = w_head.index;
        data0wr_o   = w_head.data;
        case (r_state)
            BTBQ_INIT: begin
                // The sweep owns the port outright; arbitration stall does not apply
                we0_o     = 1'b1;
                addr0wr_o = r_ptr;
                data0wr_o = '0;
                if (r_ptr == LAST_IDX) begin
                    w_state_nxt = BTBQ_RUN;
                end
            end
            BTBQ_RUN: begin
                w_ready = ~w_full;
                we0_o   = ~w_empty & ~drain_stall_i;
                w_pop   = we0_o;
                w_push  = upd.upd_valid_i & w_ready;
`ifdef BTB_UPDQ_BYPASS_EN
                // Nothing queued ahead of it, so the new update may go straight to the RAM
                if (w_empty && !drain_stall_i && upd.upd_valid_i) begin
                    w_push    = 1'b0;
                    we0_o     = 1'b1;
                    addr0wr_o = upd.upd_index_i;
                    data0wr_o = upd.upd_data_i;
                end
`endif
            end
            default: begin
                w_state_nxt = BTBQ_INIT;
            end
        endcase
    end

endmodule
